// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types for the elastic pipeline stage: occupancy-encoded
//               skid-buffer state and related helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // State value equals the number of entries held, so it drives occ_o directly
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam int unsigned C_OCC_W = 2;

    // Occupancy view of the state encoding
    function automatic logic [C_OCC_W-1:0] state_to_occ(input skid_state_e s);
        return C_OCC_W'(s);
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value instead of
//               wrapping. Cleared only by the asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = (r_cnt == {CNT_W{1'b1}});

    // Count requested cycles, holding once the maximum is reached
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cnt <= '0;
        end else if (inc_i && !w_at_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage
// Description : Elastic valid/ready pipeline register with a 2-entry skid
//               buffer. in_ready_o depends only on state and flush, never on
//               out_ready_i. Includes redirect flush and a saturating
//               back-pressure cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    skid_state_e       r_state;
    skid_state_e       w_state_nxt;

    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    logic              w_push;
    logic              w_pop;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;
    logic              w_stall;

    // Handshake signals. Flush masks both ready and valid, so a flush cycle
    // can never produce a push or a pop.
    assign in_ready_o  = (r_state != ST_TWO)   && !flush_i;
    assign out_valid_o = (r_state != ST_EMPTY) && !flush_i;
    assign w_push      = in_valid_i  && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i;

    // State register: occupancy of the stage
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: flush empties the stage, otherwise track push/pop
    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_push) w_state_nxt = ST_ONE;
                end
                ST_ONE: begin
                    if (w_push && !w_pop)      w_state_nxt = ST_TWO;
                    else if (w_pop && !w_push) w_state_nxt = ST_EMPTY;
                end
                ST_TWO: begin
                    if (w_pop) w_state_nxt = ST_ONE;
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Output decode: which data register loads from where this cycle
    always_comb begin
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                w_load_main_in = w_push;
            end
            ST_ONE: begin
                // Simultaneous push/pop replaces the head; push alone overflows
                // into the skid slot so the head keeps FIFO order.
                w_load_main_in = w_push && w_pop;
                w_load_skid    = w_push && !w_pop;
            end
            ST_TWO: begin
                w_load_main_skid = w_pop;
            end
            default: begin
                w_load_main_in   = 1'b0;
            end
        endcase
    end

    // Head register: always the oldest held payload, cleared by reset only
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_main <= '0;
        end else if (w_load_main_in) begin
            r_main <= in_data_i;
        end else if (w_load_main_skid) begin
            r_main <= r_skid;
        end
    end

    // Overflow register: only meaningful in ST_TWO, so it carries no reset
    always_ff @(posedge clk_i) begin
        if (w_load_skid) begin
            r_skid <= in_data_i;
        end
    end

    assign out_data_o = r_main;
    assign occ_o      = state_to_occ(r_state);

    // Back-pressure: valid payload offered but not taken
    assign w_stall = out_valid_o && !out_ready_i;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .inc_i    (w_stall),
        .cnt_o    (stall_cnt_o)
    );

endmodule : pipe_skid_stage
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_stage
// Description : Directed bench for pipe_skid_stage: vector table for the
//               handshake/flush behaviour plus hand sequences for counter
//               saturation and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

    typedef struct {
        logic        iv;
        logic [63:0] id;
        logic        ordy;
        logic        fl;
        logic        e_rdy;
        logic        e_vld;
        logic [63:0] e_data;
        logic [1:0]  e_occ;
        logic [31:0] e_stall;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  occ;
    logic [31:0] stall_cnt;

    logic        s_flush;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_data;
    logic [1:0]  s_occ;
    logic [2:0]  s_stall_cnt;

    int   n_checks;
    int   n_fail;
    vec_t vecs[32];
    int   nv;

    pipe_skid_stage #(.DATA_W(64), .CNT_W(32)) dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .occ_o       (occ),
        .stall_cnt_o (stall_cnt)
    );

    pipe_skid_stage #(.DATA_W(8), .CNT_W(3)) dut3 (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .flush_i     (s_flush),
        .in_valid_i  (s_in_valid),
        .in_ready_o  (s_in_ready),
        .in_data_i   (s_in_data),
        .out_valid_o (s_out_valid),
        .out_ready_i (s_out_ready),
        .out_data_o  (s_out_data),
        .occ_o       (s_occ),
        .stall_cnt_o (s_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [63:0] id, input logic ordy, input logic fl,
                       input logic e_rdy, input logic e_vld, input logic [63:0] e_data,
                       input logic [1:0] e_occ, input logic [31:0] e_stall);
        vecs[nv].iv      = iv;
        vecs[nv].id      = id;
        vecs[nv].ordy    = ordy;
        vecs[nv].fl      = fl;
        vecs[nv].e_rdy   = e_rdy;
        vecs[nv].e_vld   = e_vld;
        vecs[nv].e_data  = e_data;
        vecs[nv].e_occ   = e_occ;
        vecs[nv].e_stall = e_stall;
        nv++;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nv       = 0;
        clk      = 1'b0;
        reset_n  = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b0;
        s_flush     = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b0;

        // Columns: in_valid, in_data, out_ready, flush | ready, valid, data, occ, stall
        // (expected values are those seen before the clock edge of that row)
        // Streaming 0x1..0x8 with downstream always ready
        add(1, 64'h1, 1, 0,  1, 0, 64'h0, 2'd0, 0);
        for (int k = 2; k <= 8; k++) begin
            add(1, 64'(k), 1, 0,  1, 1, 64'(k - 1), 2'd1, 0);
        end
        add(0, 64'h0, 1, 0,  1, 1, 64'h8, 2'd1, 0);
        add(0, 64'h0, 1, 0,  1, 0, 64'h0, 2'd0, 0);
        // Skid: fill with 0xA,0xB under back-pressure, then drain
        add(1, 64'hA, 0, 0,  1, 0, 64'h0, 2'd0, 0);
        add(1, 64'hB, 0, 0,  1, 1, 64'hA, 2'd1, 0);
        add(0, 64'h0, 0, 0,  0, 1, 64'hA, 2'd2, 1);
        add(0, 64'h0, 1, 0,  0, 1, 64'hA, 2'd2, 2);
        add(0, 64'h0, 1, 0,  1, 1, 64'hB, 2'd1, 2);
        add(0, 64'h0, 1, 0,  1, 0, 64'h0, 2'd0, 2);
        // Flush with two entries held and a payload offered
        add(1, 64'hC, 0, 0,  1, 0, 64'h0, 2'd0, 2);
        add(1, 64'hD, 0, 0,  1, 1, 64'hC, 2'd1, 2);
        add(1, 64'hE, 0, 1,  0, 0, 64'h0, 2'd2, 3);
        add(0, 64'h0, 1, 0,  1, 0, 64'h0, 2'd0, 3);
        add(0, 64'h0, 1, 0,  1, 0, 64'h0, 2'd0, 3);
        // Flush with one entry held: ready must still drop
        add(1, 64'h11, 0, 0, 1, 0, 64'h0, 2'd0, 3);
        add(1, 64'h12, 1, 1, 0, 0, 64'h0, 2'd1, 3);
        add(0, 64'h0, 1, 0,  1, 0, 64'h0, 2'd0, 3);

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'h0);
        check("reset in_ready",  64'(in_ready),  64'h1);
        check("reset occ",       64'(occ),       64'h0);
        check("reset stall_cnt", 64'(stall_cnt), 64'h0);
        check("reset out_data",  out_data,       64'h0);
        reset_n = 1'b1;

        for (int i = 0; i < nv; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            #1;
            check($sformatf("vec%0d in_ready", i),  64'(in_ready),  64'(vecs[i].e_rdy));
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_vld));
            check($sformatf("vec%0d occ", i),       64'(occ),       64'(vecs[i].e_occ));
            check($sformatf("vec%0d stall", i),     64'(stall_cnt), 64'(vecs[i].e_stall));
            if (vecs[i].e_vld) begin
                check($sformatf("vec%0d out_data", i), out_data, vecs[i].e_data);
            end
            @(posedge clk);
            #1;
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Counter saturation on the 3-bit instance: one entry held, never taken
        s_in_valid  = 1'b1;
        s_in_data   = 8'h5A;
        s_out_ready = 1'b0;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        check("sat pre stall", 64'(s_stall_cnt), 64'h0);
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (n == 6) check("sat stall 6", 64'(s_stall_cnt), 64'h6);
        end
        check("sat stall 10",  64'(s_stall_cnt), 64'h7);
        check("sat occ",       64'(s_occ),       64'h1);
        check("sat out_data",  64'(s_out_data),  64'h5A);

        // Asynchronous reset with two entries held
        in_valid  = 1'b1;
        in_data   = 64'h21;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_data = 64'h22;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre-areset occ", 64'(occ), 64'h2);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset occ",       64'(occ),       64'h0);
        check("areset out_valid", 64'(out_valid), 64'h0);
        check("areset in_ready",  64'(in_ready),  64'h1);
        check("areset stall_cnt", 64'(stall_cnt), 64'h0);
        check("areset out_data",  out_data,       64'h0);
        reset_n = 1'b1;

        // Stage recovers with normal 1-cycle latency
        in_valid  = 1'b1;
        in_data   = 64'h31;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("recover out_valid", 64'(out_valid), 64'h1);
        check("recover out_data",  out_data,       64'h31);
        check("recover occ",       64'(occ),       64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_skid_stage
`default_nettype wire
